pip_classifier: RTL and testbench

//  Parametrised successor of the packet input pipeline: fixed-latency delay line that classifies each

---
 rtl/pip_pkg.sv | 34 +++
 rtl/pip_tag_fifo.sv | 69 ++++++
 rtl/pip_classifier.sv | 195 +++++++++++++++++++
 tb/tb_pip_classifier.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared types and constants for the packet input pipeline classifier.
package pip_pkg;

    // EtherType that marks a TSMP frame unless overridden at the top.
    localparam logic [15:0] TSMP_ETYPE_DEFAULT = 16'hFF01;

    // Byte positions of the EtherType inside a frame (byte index 0 = SOF).
    localparam int ETYPE_HI_IDX = 12;
    localparam int ETYPE_LO_IDX = 13;

    // Per-frame classification result carried from the parser to the output side.
    typedef struct packed {
        logic is_tsmp;
        logic runt;
    } tag_t;

    localparam tag_t TAG_NONE = '{is_tsmp: 1'b0, runt: 1'b0};
    localparam tag_t TAG_RUNT = '{is_tsmp: 1'b0, runt: 1'b1};

    // Input-side parser position within a frame.
    typedef enum logic [1:0] {
        PS_IDLE,    // waiting for SOF
        PS_HDR,     // counting beats up to the EtherType
        PS_BODY     // tag already pushed, waiting for EOF
    } parse_state_e;

    // Frame flag is the top bit of a beat; callers zero-extend the beat to 64 bits.
    function automatic logic flag_bit(input logic [63:0] beat, input int unsigned width);
        logic [63:0] shifted;
        shifted = beat >> (width - 1);
        return shifted[0];
    endfunction

endpackage

// File: rtl/pip_tag_fifo.sv
// Small synchronous FIFO holding one classification tag per frame in flight.
module pip_tag_fifo #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] iv_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] ov_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CW'(DEPTH));
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign ov_pop_data = r_mem[r_rd_ptr];

    // Tag storage write port.
    // NOTE: the storage array has no reset; whether an entry is live is decided
    // by the pointers and count alone, so its stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= iv_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: every clocked block uses non-blocking '<=' so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sizing guarantees these never fire; they guard against a mis-set depth.
    a_no_overflow:  assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full && !i_pop));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst) !(i_pop && o_empty));

endmodule

// File: rtl/pip_classifier.sv
// Fixed-latency delay line that classifies each frame by EtherType, tags it on
// the output side, optionally drops non-TSMP frames and reports frame length.
module pip_classifier
    import pip_pkg::*;
#(
    parameter int          DATA_WIDTH    = 9,
    parameter int          DELAY         = 16,    // legal range 14..64
    parameter logic [15:0] TSMP_ETYPE    = TSMP_ETYPE_DEFAULT,
    parameter bit          DROP_NON_TSMP = 1'b0,
    parameter int          LEN_W         = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    output logic                  o_is_tsmp,
    output logic                  o_runt,
    output logic [LEN_W-1:0]      ov_frame_len,
    output logic                  o_len_valid
);

    // Enough entries for every frame that can sit in the delay line at once.
    localparam int TAG_DEPTH = DELAY / 2 + 1;
    // Delay stages ahead of the output register; together they give DELAY cycles.
    localparam int NSTG      = DELAY - 1;
    localparam logic [3:0]       IDX_HI  = 4'(ETYPE_HI_IDX);
    localparam logic [3:0]       IDX_LO  = 4'(ETYPE_LO_IDX);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    // ---------------- input-side parser ----------------
    parse_state_e r_state, w_state_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [7:0]   r_hi, w_hi_nxt;
    logic         w_in_flag;
    logic         w_push;
    tag_t         w_push_tag;

    assign w_in_flag = flag_bit(64'(iv_data), DATA_WIDTH);

    // Parser state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PS_IDLE;
            r_idx   <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hi    <= w_hi_nxt;
        end
    end

    // Parser next state: track byte index, capture EtherType, push exactly one tag per frame.
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred; blocking '=' is correct in combinational code.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hi_nxt    = r_hi;
        w_push      = 1'b0;
        w_push_tag  = TAG_NONE;
        if (i_data_wr) begin
            unique case (r_state)
                PS_IDLE: begin
                    if (w_in_flag) begin
                        w_state_nxt = PS_HDR;
                        w_idx_nxt   = 4'd1;
                    end
                end
                PS_HDR: begin
                    w_idx_nxt = r_idx + 4'd1;
                    if (r_idx == IDX_HI) w_hi_nxt = iv_data[7:0];
                    if (r_idx == IDX_LO) begin
                        w_push     = 1'b1;
                        w_push_tag = '{is_tsmp: ({r_hi, iv_data[7:0]} == TSMP_ETYPE), runt: 1'b0};
                        w_state_nxt = w_in_flag ? PS_IDLE : PS_BODY;
                    end else if (w_in_flag) begin
                        // Frame ended before the EtherType was complete.
                        w_push      = 1'b1;
                        w_push_tag  = TAG_RUNT;
                        w_state_nxt = PS_IDLE;
                    end
                end
                PS_BODY: begin
                    if (w_in_flag) w_state_nxt = PS_IDLE;
                end
                default: w_state_nxt = PS_IDLE;
            endcase
        end
    end

    // ---------------- delay line ----------------
    logic [DATA_WIDTH-1:0] r_dly_data [NSTG];
    logic [NSTG-1:0]       r_dly_wr;

    // Shift beats and bubbles through unchanged; cleared on reset so no pre-reset beat re-emerges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NSTG; i++) r_dly_data[i] <= '0;
            r_dly_wr <= '0;
        end else begin
            r_dly_data[0] <= iv_data;
            for (int i = 1; i < NSTG; i++) r_dly_data[i] <= r_dly_data[i-1];
            r_dly_wr <= {r_dly_wr[NSTG-2:0], i_data_wr};
        end
    end

    // ---------------- output side ----------------
    logic [DATA_WIDTH-1:0] w_x_data;
    logic                  w_x_wr, w_x_flag, w_x_sof, w_x_eof, w_x_in, w_keep;
    logic                  r_o_in_frame;
    tag_t                  r_tag, w_cur_tag, w_pop_tag, w_fifo_tag;
    logic                  w_fifo_empty, w_fifo_full, w_fifo_push, w_fifo_pop;
    logic [LEN_W-1:0]      r_cnt, w_cnt_nxt, r_len;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_wr, r_len_valid;

    assign w_x_data = r_dly_data[NSTG-1];
    assign w_x_wr   = r_dly_wr[NSTG-1];
    assign w_x_flag = flag_bit(64'(w_x_data), DATA_WIDTH);
    assign w_x_sof  = w_x_wr && w_x_flag && !r_o_in_frame;
    assign w_x_eof  = w_x_wr && w_x_flag && r_o_in_frame;
    assign w_x_in   = w_x_sof || r_o_in_frame;

    // When the EtherType arrives in the very cycle its SOF leaves the delay line
    // the FIFO is still empty, so the freshly computed tag is forwarded directly.
    assign w_fifo_push = w_push && !(w_x_sof && w_fifo_empty);
    assign w_fifo_pop  = w_x_sof && !w_fifo_empty;
    assign w_pop_tag   = !w_fifo_empty ? w_fifo_tag : (w_push ? w_push_tag : TAG_RUNT);

    pip_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH ($bits(tag_t))
    ) u_tag_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_fifo_push),
        .iv_push_data (w_push_tag),
        .i_pop        (w_fifo_pop),
        .ov_pop_data  (w_fifo_tag),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full)
    );

    // Tag of the beat about to be registered: fresh on SOF, held for the rest of the frame.
    assign w_cur_tag = w_x_sof ? w_pop_tag : r_tag;
    assign w_keep    = !DROP_NON_TSMP || (w_x_in && w_cur_tag.is_tsmp && !w_cur_tag.runt);

    // Saturating count of valid beats from SOF through the current beat.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_x_sof) begin
            w_cnt_nxt = LEN_W'(1);
        end else if (r_o_in_frame && w_x_wr && (r_cnt != LEN_MAX)) begin
            w_cnt_nxt = r_cnt + LEN_W'(1);
        end
    end

    // Output register stage: beat, gated valid, held tag and EOF length report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data   <= '0;
            r_out_wr     <= 1'b0;
            r_o_in_frame <= 1'b0;
            r_tag        <= TAG_NONE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_len_valid  <= 1'b0;
        end else begin
            r_out_data   <= w_x_data;
            r_out_wr     <= w_x_wr && w_keep;
            r_o_in_frame <= w_x_sof ? 1'b1 : (w_x_eof ? 1'b0 : r_o_in_frame);
            r_tag        <= w_x_in ? w_cur_tag : TAG_NONE;
            r_cnt        <= w_cnt_nxt;
            r_len        <= (w_x_eof && w_keep) ? w_cnt_nxt : '0;
            r_len_valid  <= w_x_eof && w_keep;
        end
    end

    assign ov_data      = r_out_data;
    assign o_data_wr    = r_out_wr;
    assign o_is_tsmp    = r_tag.is_tsmp;
    assign o_runt       = r_tag.runt;
    assign ov_frame_len = r_len;
    assign o_len_valid  = r_len_valid;

    // A frame leaving the delay line must always find its tag.
    a_tag_present: assert property (@(posedge i_clk) disable iff (i_rst)
                                    !(w_x_sof && w_fifo_empty && !w_push));
    a_fifo_room:   assert property (@(posedge i_clk) disable iff (i_rst)
                                    !(w_fifo_push && w_fifo_full && !w_fifo_pop));

endmodule

// File: tb/tb_pip_classifier.sv
// Randomised bench for pip_classifier: two instances (tag-only, drop mode with a
// narrow length field) share one input stream; expected outputs come from a
// per-cycle record of what was sent, annotated with frame-level class and length.
module tb_pip_classifier;

    localparam int DW        = 9;
    localparam int DELAY     = 16;
    localparam int LEN_A     = 11;
    localparam int LEN_B     = 5;
    localparam int LMAX_A    = (1 << LEN_A) - 1;
    localparam int LMAX_B    = (1 << LEN_B) - 1;
    localparam int MAXC      = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    = 1'b1;
    logic [DW-1:0] din    = '0;
    logic          din_wr = 1'b0;

    logic [DW-1:0]    a_data, b_data;
    logic             a_wr, b_wr, a_tsmp, b_tsmp, a_runt, b_runt, a_lv, b_lv;
    logic [LEN_A-1:0] a_len;
    logic [LEN_B-1:0] b_len;

    pip_classifier #(
        .DATA_WIDTH(DW), .DELAY(DELAY), .TSMP_ETYPE(16'hFF01), .DROP_NON_TSMP(1'b0), .LEN_W(LEN_A)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .iv_data(din), .i_data_wr(din_wr),
        .ov_data(a_data), .o_data_wr(a_wr), .o_is_tsmp(a_tsmp), .o_runt(a_runt),
        .ov_frame_len(a_len), .o_len_valid(a_lv)
    );

    pip_classifier #(
        .DATA_WIDTH(DW), .DELAY(DELAY), .TSMP_ETYPE(16'hFF01), .DROP_NON_TSMP(1'b1), .LEN_W(LEN_B)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .iv_data(din), .i_data_wr(din_wr),
        .ov_data(b_data), .o_data_wr(b_wr), .o_is_tsmp(b_tsmp), .o_runt(b_runt),
        .ov_frame_len(b_len), .o_len_valid(b_lv)
    );

    // What was presented in each input cycle, plus the class of the frame it belongs to.
    logic [DW-1:0] h_data [MAXC];
    bit            h_wr   [MAXC];
    bit            h_tsmp [MAXC];
    bit            h_runt [MAXC];
    bit            h_eof  [MAXC];
    int            h_len  [MAXC];

    int cyc      = 0;
    int last_rst = -1;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Output after edge cyc reflects the input presented DELAY cycles earlier,
    // unless a reset has intervened since then.
    task automatic compare();
        int            k;
        bit            z;
        logic [DW-1:0] e_data;
        bit            e_wr, e_ts, e_rn, e_eof;
        int            e_len;
        k = cyc - DELAY;
        z = (k < 0) || (k <= last_rst);
        e_data = '0; e_wr = 0; e_ts = 0; e_rn = 0; e_eof = 0; e_len = 0;
        if (!z) begin
            e_data = h_data[k];
            e_wr   = h_wr[k];
            e_ts   = h_tsmp[k];
            e_rn   = h_runt[k];
            e_eof  = h_eof[k];
            e_len  = h_len[k];
        end
        check("a_data", 32'(a_data), 32'(e_data));
        check("a_wr",   32'(a_wr),   32'(e_wr));
        check("a_tsmp", 32'(a_tsmp), 32'(e_ts));
        check("a_runt", 32'(a_runt), 32'(e_rn));
        check("a_lv",   32'(a_lv),   32'(e_eof));
        if (e_eof) check("a_len", 32'(a_len), 32'((e_len > LMAX_A) ? LMAX_A : e_len));
        check("b_data", 32'(b_data), 32'(e_data));
        check("b_wr",   32'(b_wr),   32'(e_wr && e_ts && !e_rn));
        check("b_tsmp", 32'(b_tsmp), 32'(e_ts));
        check("b_runt", 32'(b_runt), 32'(e_rn));
        check("b_lv",   32'(b_lv),   32'(e_eof && e_ts));
        if (e_eof && e_ts) check("b_len", 32'(b_len), 32'((e_len > LMAX_B) ? LMAX_B : e_len));
        if (z) begin
            check("a_len_zero", 32'(a_len), 32'd0);
            check("b_len_zero", 32'(b_len), 32'd0);
        end
    endtask

    task automatic tick(input bit r, input bit wr, input logic [DW-1:0] d,
                        input bit ts, input bit rn, input bit eof, input int len);
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        rst    = r;
        din_wr = wr;
        din    = d;
        h_data[cyc] = d;
        h_wr[cyc]   = wr && !r;
        h_tsmp[cyc] = ts && !r;
        h_runt[cyc] = rn && !r;
        h_eof[cyc]  = eof && !r;
        h_len[cyc]  = len;
        @(posedge clk);
        #1;
        if (r) last_rst = cyc;
        cyc++;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, DW'($urandom), 0, 0, 0, 0);
    endtask

    // Sends an n-beat frame; cut>0 stops after that many beats without EOF.
    // Bubble mode keeps the 14-beat header within DELAY cycles (two bubbles),
    // then idles every third cycle.
    task automatic send_frame(input int n, input logic [7:0] b12, input logic [7:0] b13,
                              input bit bub, input bit directed, input int cut);
        bit         ts, rn, flag;
        logic [7:0] by;
        int         last;
        rn   = (n < 14);
        ts   = !rn && ({b12, b13} == 16'hFF01);
        last = (cut > 0) ? cut : n;
        for (int i = 0; i < last; i++) begin
            if (bub && i > 0 && (i == 5 || i == 10 || (i >= 14 && i % 2 == 0)))
                tick(0, 0, DW'($urandom), ts, rn, 0, 0);
            if (i == 12)      by = b12;
            else if (i == 13) by = b13;
            else if (directed) by = (i < 2) ? 8'h01 : ((i < 12) ? 8'h00 : 8'($urandom));
            else               by = 8'($urandom);
            flag = (i == 0) || (i == n - 1);
            tick(0, 1, {flag, by}, ts, rn, (i == n - 1), n);
        end
    endtask

    initial begin
        logic [7:0] e12, e13;
        int         sel;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1, 0, '0, 0, 0, 0, 0);
        idle(2);

        // 82-beat TSMP frame, then the same frame with a foreign EtherType
        send_frame(82, 8'hFF, 8'h01, 0, 1, 0);
        idle(2);
        send_frame(82, 8'hF1, 8'h00, 0, 1, 0);
        idle(3);

        // Runt back-to-back with TSMP, then classification boundaries
        send_frame(6,  8'h00, 8'h00, 0, 1, 0);
        send_frame(30, 8'hFF, 8'h01, 0, 1, 0);
        send_frame(6,  8'h00, 8'h00, 0, 0, 0);
        send_frame(13, 8'hFF, 8'h01, 0, 0, 0);
        send_frame(14, 8'hFF, 8'h01, 0, 0, 0);
        send_frame(14, 8'hFF, 8'h00, 0, 0, 0);
        send_frame(20, 8'hFE, 8'h01, 0, 0, 0);
        idle(4);

        // Eight back-to-back minimum frames
        for (int i = 0; i < 8; i++) send_frame(2, 8'h00, 8'h00, 0, 0, 0);
        send_frame(16, 8'hFF, 8'h01, 0, 0, 0);
        idle(4);

        // Bubbles inside a TSMP frame
        send_frame(60, 8'hFF, 8'h01, 1, 1, 0);
        idle(3);

        // Reset mid-payload, then a clean frame
        send_frame(82, 8'hFF, 8'h01, 0, 1, 30);
        tick(1, 0, '0, 0, 0, 0, 0);
        send_frame(40, 8'hFF, 8'h01, 0, 1, 0);
        idle(3);

        // Random frames
        for (int f = 0; f < 60; f++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1:    begin e12 = 8'hFF; e13 = 8'h01; end
                2:       begin e12 = 8'hFF; e13 = 8'h00; end
                default: begin e12 = 8'($urandom); e13 = 8'($urandom); end
            endcase
            send_frame(int'($urandom_range(2, 45)), e12, e13, bit'($urandom_range(0, 1)), 0, 0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(DELAY + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
